// File: rtl/display_line_fetch.sv
// Display line fetch: two 32-byte color line banks, one shown while the
// other is refilled from memory once per cell row, paced by VGA timing.
module display_line_fetch #(
  parameter logic [15:0] BASE_ADDR  = 16'h0200,
  parameter int          CELL_LINES = 15,
  parameter int          H_TOTAL    = 800,
  parameter int          V_TOTAL    = 525,
  parameter int          V_ACTIVE   = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [15:0] color_address,
  output logic [7:0]  color_data,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        underrun_clr,
  output logic        underrun
);

  localparam int CLW = $clog2(CELL_LINES);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [CLW-1:0] cell_line_q, cell_line_d;
  logic [4:0]     cell_row_q, cell_row_d;
  logic [4:0]     n_q, n_d;
  logic [4:0]     row_q, row_d;
  logic           disp_q, disp_d;
  logic [1:0][31:0][7:0] bank_q, bank_d;
  logic           mem_req_q, mem_req_d;
  logic [15:0]    mem_addr_q, mem_addr_d;
  logic           underrun_q, underrun_d;

  logic        line_end;
  logic        frame_end;
  logic [9:0]  next_y;
  logic        swap;
  logic        start;
  logic [4:0]  start_row;
  logic        ack;
  logic        last;
  logic        wr;
  logic        busy;
  logic        in_page;

  function automatic logic [15:0] row_base(
    input logic [4:0] r
  );
    return BASE_ADDR + {6'd0, r, 5'd0};
  endfunction

  assign line_end  = pixel_x == 10'(H_TOTAL-1);
  assign frame_end = pixel_y == 10'(V_TOTAL-1);
  assign next_y    = frame_end ? 10'd0
                   : pixel_y + 10'd1;

  assign swap = line_end
             && (next_y < 10'(V_ACTIVE))
             && (cell_line_d == '0);

  assign start = (swap && cell_row_d != 5'd31)
              || (line_end
                  && pixel_y == 10'(V_ACTIVE-1));

  assign start_row = swap ? cell_row_d + 5'd1
                   : 5'd0;

  assign ack  = mem_ack && (state_q != IDLE);
  assign last = n_q == 5'd31;
  assign wr   = (state_q == FETCH) && ack;

  // A fetch finishing this very cycle is not late.
  assign busy = (state_q != IDLE)
             && !(wr && last);

  assign in_page =
    ({1'b0, color_address} >= {1'b0, BASE_ADDR})
    && ({1'b0, color_address}
        < ({1'b0, BASE_ADDR} + 17'd1024));

  assign color_data = in_page
    ? bank_q[disp_q][color_address[4:0]]
    : 8'h00;

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign underrun = underrun_q;

  // Cell line/row counters describe the line after line_end.
  always_comb begin
    cell_line_d = cell_line_q;
    cell_row_d  = cell_row_q;
    if (line_end) begin
      if (frame_end) begin
        cell_line_d = '0;
        cell_row_d  = '0;
      end else if (cell_line_q
                   == CLW'(CELL_LINES-1)) begin
        cell_line_d = '0;
        cell_row_d  = cell_row_q + 5'd1;
      end else begin
        cell_line_d = cell_line_q + CLW'(1);
      end
    end
  end

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch next-state: a restart with a request in flight drains it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (start)
          state_d = ack ? FETCH : DRAIN;
        else if (ack && last)
          state_d = IDLE;
      end
      DRAIN: begin
        if (ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch outputs, bank writes, swap and underrun bookkeeping.
  always_comb begin
    disp_d     = disp_q;
    bank_d     = bank_q;
    n_d        = n_q;
    row_d      = row_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    underrun_d = underrun_q;

    if (swap) disp_d = ~disp_q;
    if (wr) bank_d[~disp_q][n_q] = mem_rdata;

    unique case (state_q)
      FETCH: begin
        if (ack) begin
          n_d        = n_q + 5'd1;
          mem_addr_d = row_base(row_q)
                     + {11'd0, n_d};
          mem_req_d  = !last;
        end
      end
      DRAIN: begin
        if (ack) begin
          n_d        = 5'd0;
          mem_addr_d = row_base(row_q);
        end
      end
      default: ;
    endcase

    if (start) begin
      row_d = start_row;
      if (state_q == IDLE || ack) begin
        n_d        = 5'd0;
        mem_req_d  = 1'b1;
        mem_addr_d = row_base(start_row);
      end
    end

    if (underrun_clr) underrun_d = 1'b0;
    if (busy && (swap || start))
      underrun_d = 1'b1;
  end

  // Datapath and timing-tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_line_q <= '0;
      cell_row_q  <= '0;
      n_q         <= '0;
      row_q       <= '0;
      disp_q      <= 1'b0;
      bank_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 16'h0000;
      underrun_q  <= 1'b0;
    end else begin
      cell_line_q <= cell_line_d;
      cell_row_q  <= cell_row_d;
      n_q         <= n_d;
      row_q       <= row_d;
      disp_q      <= disp_d;
      bank_q      <= bank_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule
